// File: rtl/branch_comparator_seq.sv
// Multi-cycle RISC-V branch comparator.
// Operands are compared CHUNK bits per cycle starting at the MSB chunk.
// The top chunk is compared signed for BLT/BGE and unsigned otherwise.
// With EARLY_EXIT the result is produced on the first differing chunk.
module branch_comparator_seq #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_flush,
  input  logic             I_valid,
  output logic             O_ready,
  input  logic [2:0]       I_funct3,
  input  logic [WIDTH-1:0] I_data1,
  input  logic [WIDTH-1:0] I_data2,
  output logic             O_valid,
  input  logic             I_ready,
  output logic             O_branch_equal,
  output logic             O_branch_lessthan,
  output logic             O_taken,
  output logic             O_illegal
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               found, found_nxt;
  logic               lt_hold, lt_hold_nxt;
  logic [WIDTH-1:0]   opa_p0, opb_p0;
  logic [2:0]         f3_p0;
  logic [CHUNK-1:0]   ca, cb;
  logic               accept, top, diff, lt_now;
  logic               finish, res_eq, res_lt;

  // Chunk less-than; only the chunk holding the sign bit is ever compared signed.
  function automatic logic chunk_lt(input logic [CHUNK-1:0] a, input logic [CHUNK-1:0] b,
                                    input logic sgn);
    logic signed [CHUNK-1:0] sa, sb;
    sa = a;
    sb = b;
    return sgn ? (sa < sb) : (a < b);
  endfunction

  // Branch decision from equal/less-than; illegal encodings never take the branch.
  function automatic logic taken_of(input logic [2:0] f3, input logic eq, input logic lt);
    logic t;
    case (f3)
      3'b000:          t = eq;
      3'b001:          t = !eq;
      3'b100, 3'b110:  t = lt;
      3'b101, 3'b111:  t = !lt;
      default:         t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic illegal_of(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  assign accept  = I_valid && (state == IDLE) && !I_flush;
  assign O_ready = (state == IDLE);
  assign O_valid = (state == DONE);
  assign ca      = opa_p0[idx*CHUNK +: CHUNK];
  assign cb      = opb_p0[idx*CHUNK +: CHUNK];
  assign top     = (idx == IDX_W'(N - 1));
  assign diff    = (ca != cb);
  assign lt_now  = chunk_lt(ca, cb, top && !f3_p0[1]);

  // Next-state logic and per-chunk compare step.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    found_nxt   = found;
    lt_hold_nxt = lt_hold;
    finish      = 1'b0;
    res_eq      = 1'b0;
    res_lt      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt   = BUSY;
          idx_nxt     = IDX_W'(N - 1);
          found_nxt   = 1'b0;
          lt_hold_nxt = 1'b0;
        end
      end
      BUSY: begin
        if (I_flush) begin
          state_nxt = IDLE;
        end else begin
          // The first differing chunk decides the ordering; later chunks are ignored.
          if (diff && !found) begin
            found_nxt   = 1'b1;
            lt_hold_nxt = lt_now;
          end
          if ((EARLY_EXIT != 0) && diff) begin
            finish = 1'b1;
            res_eq = 1'b0;
            res_lt = lt_now;
          end else if (idx == '0) begin
            finish = 1'b1;
            res_eq = !found && !diff;
            res_lt = found ? lt_hold : (diff && lt_now);
          end else begin
            idx_nxt = idx - 1'b1;
          end
          if (finish) state_nxt = DONE;
        end
      end
      DONE: begin
        // Flush and consumption both return to IDLE; no accept in this cycle.
        if (I_flush || I_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state and registered result flags.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state             <= IDLE;
      idx               <= '0;
      found             <= 1'b0;
      lt_hold           <= 1'b0;
      O_branch_equal    <= 1'b0;
      O_branch_lessthan <= 1'b0;
      O_taken           <= 1'b0;
      O_illegal         <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      found   <= found_nxt;
      lt_hold <= lt_hold_nxt;
      if (finish) begin
        O_branch_equal    <= res_eq;
        O_branch_lessthan <= res_lt;
        O_taken           <= taken_of(f3_p0, res_eq, res_lt);
        O_illegal         <= illegal_of(f3_p0);
      end
    end
  end

  // Request capture: operands are sampled only at accept.
  always_ff @(posedge I_clk) begin
    if (accept) begin
      opa_p0 <= I_data1;
      opb_p0 <= I_data2;
      f3_p0  <= I_funct3;
    end
  end

endmodule

// File: tb/tb_branch_comparator_seq.sv
// Self-checking bench for branch_comparator_seq: three configurations
// (early exit, no early exit, single chunk) against a plain arithmetic model.
module tb_branch_comparator_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        irdy = 1'b1;
  logic [2:0]  vin = '0;
  logic [2:0]  fn3 = '0;
  logic [31:0] d1 = '0, d2 = '0;
  logic [2:0]  oready, ovalid, oeq, olt, otk, oil;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_comparator_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) dut0 (
    .I_clk(clk), .I_rst(rst), .I_flush(flush), .I_valid(vin[0]), .O_ready(oready[0]),
    .I_funct3(fn3), .I_data1(d1), .I_data2(d2), .O_valid(ovalid[0]), .I_ready(irdy),
    .O_branch_equal(oeq[0]), .O_branch_lessthan(olt[0]), .O_taken(otk[0]), .O_illegal(oil[0]));

  branch_comparator_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) dut1 (
    .I_clk(clk), .I_rst(rst), .I_flush(flush), .I_valid(vin[1]), .O_ready(oready[1]),
    .I_funct3(fn3), .I_data1(d1), .I_data2(d2), .O_valid(ovalid[1]), .I_ready(irdy),
    .O_branch_equal(oeq[1]), .O_branch_lessthan(olt[1]), .O_taken(otk[1]), .O_illegal(oil[1]));

  branch_comparator_seq #(.WIDTH(32), .CHUNK(32), .EARLY_EXIT(1)) dut2 (
    .I_clk(clk), .I_rst(rst), .I_flush(flush), .I_valid(vin[2]), .O_ready(oready[2]),
    .I_funct3(fn3), .I_data1(d1), .I_data2(d2), .O_valid(ovalid[2]), .I_ready(irdy),
    .O_branch_equal(oeq[2]), .O_branch_lessthan(olt[2]), .O_taken(otk[2]), .O_illegal(oil[2]));

  // Reference: whole-word comparison; latency from the highest differing bit.
  function automatic void model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input int chunk, input int ee, output int lat,
                                output logic eq, output logic lt, output logic tk, output logic il);
    int n, hb;
    n  = 32 / chunk;
    eq = (a == b);
    lt = f3[1] ? (a < b) : ($signed(a) < $signed(b));
    il = (f3 == 3'b010) || (f3 == 3'b011);
    case (f3)
      3'b000:         tk = eq;
      3'b001:         tk = !eq;
      3'b100, 3'b110: tk = lt;
      3'b101, 3'b111: tk = !lt;
      default:        tk = 1'b0;
    endcase
    if (eq || ee == 0) begin
      lat = n;
    end else begin
      hb = 0;
      for (int i = 31; i >= 0; i--) if ((a[i] ^ b[i]) && hb == 0 && i > 0) begin hb = i; break; end
      lat = n - hb / chunk;
    end
  endfunction

  // Issue one request to instance w and wait for its result; lat = -1 on timeout.
  // Entered and left at 1 time unit after a rising edge.
  task automatic run_txn(input int w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic eq, output logic lt, output logic tk,
                         output logic il);
    int n;
    n = 0;
    while (!oready[w] && n < 50) begin @(posedge clk); #1; n++; end
    fn3 = f3; d1 = a; d2 = b; vin[w] = 1'b1;
    @(posedge clk); #1;
    vin[w] = 1'b0;
    d1 = $urandom; d2 = $urandom; fn3 = 3'($urandom);
    lat = -1; eq = 1'bx; lt = 1'bx; tk = 1'bx; il = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ovalid[w]) begin
        lat = i; eq = oeq[w]; lt = olt[w]; tk = otk[w]; il = oil[w];
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if (oready[0] !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", oready[0]); end
    checks++;
    if ({ovalid[0], oeq[0], olt[0], otk[0], oil[0]} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs got %b want 00000", {ovalid[0], oeq[0], olt[0], otk[0], oil[0]});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int lat; logic eq, lt, tk, il;
    run_txn(0, 3'b000, 32'd1, 32'd1, lat, eq, lt, tk, il);
    checks++;
    if ({lat, eq, lt, tk, il} !== {32'd4, 4'b1010}) begin
      errors++; $display("FAIL beq_equal got lat=%0d e/l/t/i=%b%b%b%b want lat=4 1010", lat, eq, lt, tk, il);
    end
    run_txn(0, 3'b100, 32'hFFFF_FFFF, 32'h0, lat, eq, lt, tk, il);
    checks++;
    if ({lat, eq, lt, tk, il} !== {32'd1, 4'b0110}) begin
      errors++; $display("FAIL blt_neg got lat=%0d e/l/t/i=%b%b%b%b want lat=1 0110", lat, eq, lt, tk, il);
    end
    run_txn(0, 3'b110, 32'hFFFF_FFFF, 32'h0, lat, eq, lt, tk, il);
    checks++;
    if ({lat, eq, lt, tk, il} !== {32'd1, 4'b0000}) begin
      errors++; $display("FAIL bltu_big got lat=%0d e/l/t/i=%b%b%b%b want lat=1 0000", lat, eq, lt, tk, il);
    end
    run_txn(0, 3'b101, 32'hFFFF_FFFE, 32'hFFFF_FFFF, lat, eq, lt, tk, il);
    checks++;
    if ({lat, eq, lt, tk, il} !== {32'd4, 4'b0100}) begin
      errors++; $display("FAIL bge_last got lat=%0d e/l/t/i=%b%b%b%b want lat=4 0100", lat, eq, lt, tk, il);
    end
    run_txn(0, 3'b001, 32'h1234_5600, 32'h1234_5601, lat, eq, lt, tk, il);
    checks++;
    if ({lat, eq, tk, il} !== {32'd4, 3'b010}) begin
      errors++; $display("FAIL bne_low got lat=%0d e/t/i=%b%b%b want lat=4 010", lat, eq, tk, il);
    end
    run_txn(0, 3'b010, 32'd3, 32'd3, lat, eq, lt, tk, il);
    checks++;
    if ({lat, eq, lt, tk, il} !== {32'd4, 4'b1001}) begin
      errors++; $display("FAIL illegal_f3 got lat=%0d e/l/t/i=%b%b%b%b want lat=4 1001", lat, eq, lt, tk, il);
    end
  endtask

  task automatic test_early_exit_off();
    int lat; logic eq, lt, tk, il;
    run_txn(1, 3'b100, 32'h8000_0000, 32'h1, lat, eq, lt, tk, il);
    checks++;
    if ({lat, eq, lt, tk, il} !== {32'd4, 4'b0110}) begin
      errors++; $display("FAIL ee0_blt got lat=%0d e/l/t/i=%b%b%b%b want lat=4 0110", lat, eq, lt, tk, il);
    end
  endtask

  task automatic test_single_chunk();
    int lat; logic eq, lt, tk, il;
    run_txn(2, 3'b000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, lat, eq, lt, tk, il);
    checks++;
    if ({lat, eq, tk} !== {32'd1, 2'b11}) begin
      errors++; $display("FAIL chunk32_beq got lat=%0d e/t=%b%b want lat=1 11", lat, eq, tk);
    end
  endtask

  task automatic test_random(input int w, input int chunk, input int ee, input int count);
    int lat, mlat, mode; logic eq, lt, tk, il, meq, mlt, mtk, mil;
    logic [31:0] a, b; logic [2:0] f3;
    for (int k = 0; k < count; k++) begin
      a = $urandom; mode = $urandom_range(0, 3); f3 = 3'($urandom_range(0, 7));
      case (mode)
        0:       b = a;
        1:       b = $urandom;
        2:       b = a ^ (32'h1 << $urandom_range(0, 31));
        default: b = a ^ ($urandom & 32'h0000_00FF);
      endcase
      model(f3, a, b, chunk, ee, mlat, meq, mlt, mtk, mil);
      run_txn(w, f3, a, b, lat, eq, lt, tk, il);
      checks++;
      if ({lat, eq, lt, tk, il} !== {mlat, meq, mlt, mtk, mil}) begin
        errors++;
        $display("FAIL random_u%0d f3=%b a=%h b=%h got lat=%0d e/l/t/i=%b%b%b%b want lat=%0d %b%b%b%b",
                 w, f3, a, b, lat, eq, lt, tk, il, mlat, meq, mlt, mtk, mil);
      end
    end
  endtask

  task automatic test_backpressure();
    logic seen;
    irdy = 1'b0;
    fn3 = 3'b100; d1 = 32'hFFFF_FFFF; d2 = 32'h0; vin[0] = 1'b1;
    @(posedge clk); #1;
    vin[0] = 1'b0;
    @(posedge clk); #1;
    seen = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d1 = $urandom; d2 = $urandom; fn3 = 3'($urandom);
      if ({ovalid[0], oready[0], oeq[0], olt[0], otk[0], oil[0]} !== 6'b100110) seen = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL bp_hold got stable=%b want 1", seen); end
    checks++;
    if ({ovalid[0], oready[0]} !== 2'b10) begin
      errors++; $display("FAIL bp_last got v/r=%b want 10", {ovalid[0], oready[0]});
    end
    irdy = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ovalid[0], oready[0], olt[0], otk[0]} !== 4'b0111) begin
      errors++; $display("FAIL bp_release got v/r/l/t=%b want 0111", {ovalid[0], oready[0], olt[0], otk[0]});
    end
  endtask

  task automatic test_flush();
    logic seen;
    // Flush in BUSY cycle 2.
    fn3 = 3'b000; d1 = 32'd7; d2 = 32'd7; vin[0] = 1'b1;
    @(posedge clk); #1;
    vin[0] = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    seen = 1'b0;
    checks++;
    if ({ovalid[0], oready[0]} !== 2'b01) begin
      errors++; $display("FAIL flush_busy got v/r=%b want 01", {ovalid[0], oready[0]});
    end
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (ovalid[0]) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL flush_busy_novalid got %b want 0", seen); end
    // Flush in DONE under back-pressure.
    irdy = 1'b0;
    fn3 = 3'b100; d1 = 32'hFFFF_FFFF; d2 = 32'h0; vin[0] = 1'b1;
    @(posedge clk); #1;
    vin[0] = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if ({ovalid[0], oready[0]} !== 2'b01) begin
      errors++; $display("FAIL flush_done got v/r=%b want 01", {ovalid[0], oready[0]});
    end
    irdy = 1'b1;
    // Flush in IDLE blocks the accept.
    fn3 = 3'b000; d1 = 32'd1; d2 = 32'd1; vin[0] = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    vin[0] = 1'b0; flush = 1'b0;
    checks++;
    if (oready[0] !== 1'b1) begin errors++; $display("FAIL flush_idle_ready got %b want 1", oready[0]); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (ovalid[0]) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL flush_idle_novalid got %b want 0", seen); end
  endtask

  task automatic test_reset_midbusy();
    int lat; logic eq, lt, tk, il, seen;
    run_txn(0, 3'b000, 32'd5, 32'd5, lat, eq, lt, tk, il);
    @(posedge clk); #1;
    fn3 = 3'b000; d1 = 32'd9; d2 = 32'd9; vin[0] = 1'b1;
    @(posedge clk); #1;
    vin[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({oready[0], ovalid[0], oeq[0], olt[0], otk[0], oil[0]} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_busy got r/v/e/l/t/i=%b want 100000",
               {oready[0], ovalid[0], oeq[0], olt[0], otk[0], oil[0]});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (ovalid[0]) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL reset_busy_novalid got %b want 0", seen); end
  endtask

  initial begin
    #1;
    test_reset();
    test_directed();
    test_early_exit_off();
    test_single_chunk();
    test_random(0, 8, 1, 40);
    test_random(1, 8, 0, 30);
    test_random(2, 32, 1, 20);
    test_backpressure();
    test_flush();
    test_reset_midbusy();
    test_random(0, 8, 1, 10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_comparator_seq.md
Name: branch_comparator_seq

Overview:
- Parametrised, multi-cycle successor to the combinational branch comparator in the RISC-V core.
- Accepts a branch request (two operands plus funct3) over a valid/ready handshake.
- Compares the operands CHUNK bits per cycle, starting at the MSB, with optional early exit on the first differing chunk.
- Returns equal, less-than, taken and illegal flags over a valid/ready handshake. Intended for area-reduced or wide-datapath (RV64) core variants.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits compared per cycle; CHUNK = WIDTH gives single-cycle compare.
EARLY_EXIT, 1, 1 = finish on the first differing chunk; 0 = always take N = WIDTH/CHUNK cycles.

Ports:
I_clk  input  1  clock, rising edge.
I_rst  input  1  asynchronous, active-high reset.
I_flush  input  1  synchronous abort of any in-flight request.
I_valid  input  1  request valid.
O_ready  output  1  request accepted when I_valid && O_ready.
I_funct3  input  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
I_data1  input  WIDTH  rs1 operand.
I_data2  input  WIDTH  rs2 operand.
O_valid  output  1  result valid.
I_ready  input  1  result consumed when O_valid && I_ready.
O_branch_equal  output  1  data1 == data2.
O_branch_lessthan  output  1  data1 < data2; signed or unsigned per funct3[1].
O_taken  output  1  branch taken.
O_illegal  output  1  funct3 is 010 or 011.

Behaviour:
- States: IDLE, BUSY, DONE. Reset (async, I_rst = 1) forces IDLE and clears all outputs except O_ready. Reset values: O_ready = 1; O_valid, O_branch_equal, O_branch_lessthan, O_taken, O_illegal = 0.
- IDLE:
  - O_ready = 1; O_ready is 0 in every other state.
  - On accept: latch data1, data2 and funct3; set chunk index idx = N-1; go to BUSY.
  - Unsigned mode = funct3[1].
- BUSY, one chunk per cycle at slice [idx*CHUNK +: CHUNK]:
  - Chunks differ: lessthan = (a < b). The comparison is signed only when idx = N-1 and mode is signed; otherwise it is unsigned. equal = 0. If EARLY_EXIT = 1, go to DONE.
  - Chunks equal and idx = 0: equal = 1, lessthan = 0, go to DONE.
  - Otherwise: decrement idx.
  - EARLY_EXIT = 0: the first differing chunk's result is held, later chunks are ignored, and DONE is always reached after N cycles.
- Latency: O_valid rises k cycles after the accept edge. k = index of the first differing chunk counted from the MSB (1..N) when EARLY_EXIT = 1, else k = N. Equal operands always give k = N.
- Result encoding:
  - taken = BEQ: eq; BNE: !eq; BLT/BLTU: lt; BGE/BGEU: !lt.
  - Illegal funct3 (010, 011): O_illegal = 1, taken = 0; eq and lt are still reported.
- DONE:
  - O_valid = 1; all result outputs held stable until O_valid && I_ready, then go to IDLE.
  - Results are registered and stay unchanged after leaving DONE until the next DONE.
  - No accept in the same cycle as result consumption; at most one request is in flight.
- I_flush:
  - In BUSY or DONE: go to IDLE next edge, O_valid = 0, no result delivered.
  - In IDLE: suppresses acceptance that cycle.
  - Flush has priority over consumption.
- Async reset mid-BUSY or mid-DONE: immediate return to IDLE with reset values; the request is lost.
- Inputs are sampled only at accept; later changes to I_data or I_funct3 have no effect.

Test Plan:
- WIDTH=32, CHUNK=8, EARLY_EXIT=1; BEQ 1 vs 1 -> O_valid 4 cycles after accept; eq=1, lt=0, taken=1.
- BLT, -1 (0xFFFFFFFF) vs 0 -> top chunk differs, O_valid after 1 cycle; eq=0, lt=1, taken=1. Same operands with BLTU -> lt=0, taken=0.
- BGE -2 vs -1 -> differ in the last chunk, 4 cycles; lt=1, taken=0. BNE 0x12345600 vs 0x12345601 -> taken=1, 4 cycles.
- EARLY_EXIT=0, BLT 0x80000000 vs 1 -> 4 cycles; lt=1 from the signed top chunk; later chunks do not overwrite.
- Back-pressure: hold I_ready=0 for 5 cycles in DONE -> outputs stable, O_ready=0; I_ready=1 -> IDLE next cycle, O_ready=1.
- Flush at BUSY cycle 2 -> IDLE, no O_valid. Async I_rst pulse mid-BUSY -> outputs at reset values immediately. funct3=010 -> O_illegal=1, taken=0. CHUNK=32 -> 1-cycle result.
